// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sweeper.
//   state_t   : sweep FSM states
//   N_INPUTS  : netlist input count
//   N_VECTORS : input combinations per sweep
//   to_gray   : binary step -> Gray-code vector
package tts_pkg;

  localparam int unsigned N_INPUTS  = 4;
  localparam int unsigned N_VECTORS = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  function automatic logic [N_INPUTS-1:0] to_gray(input logic [N_INPUTS-1:0] k);
    return k ^ (k >> 1);
  endfunction

endpackage

// File: rtl/sample_voter.sv
// Synchronises the asynchronous netlist output and majority-votes N_SAMPLES
// consecutive synchronised values.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : drop any partially accumulated vote
//   enable     : take one sample this cycle
//   din        : raw netlist output (asynchronous to clk)
//   last       : this enabled cycle takes the final sample of the window
//   valid      : one-cycle pulse, result holds the vote (cycle after last)
//   result     : majority value
module sample_voter #(
  parameter int unsigned N_SAMPLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic din,
  output logic last,
  output logic valid,
  output logic result
);

  localparam int unsigned SW = $clog2(N_SAMPLES + 1);

  logic          sync1;
  logic          sync2;
  logic [SW-1:0] samp_cnt;
  logic [SW-1:0] ones_cnt;
  logic [SW-1:0] ones_total;

  assign last = enable && (samp_cnt == SW'(N_SAMPLES - 1));

  always_comb begin
    ones_total = ones_cnt + SW'(sync2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt <= '0;
      ones_cnt <= '0;
      valid    <= 1'b0;
      result   <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clear) begin
        samp_cnt <= '0;
        ones_cnt <= '0;
      end else if (enable) begin
        if (last) begin
          result   <= (ones_total > SW'(N_SAMPLES / 2));
          valid    <= 1'b1;
          samp_cnt <= '0;
          ones_cnt <= '0;
        end else begin
          samp_cnt <= samp_cnt + 1'b1;
          ones_cnt <= ones_total;
        end
      end
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 16 input combinations of a 4-input combinational netlist,
// votes the settled output for each vector and assembles a truth-table
// signature, then compares it against EXPECTED.
// Optional: define SWEEP_GRAY_EN to apply vectors in Gray-code order
// (signature and latency unchanged, vec_idx reports the Gray vector).
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a sweep when idle
//   abort       : terminate a running sweep (wins over start)
//   dut_out     : netlist output, asynchronous
//   in1..in4    : netlist inputs, in1 = vector MSB
//   busy        : sweep in progress
//   done        : one-cycle completion pulse
//   signature   : captured truth table, bit v = netlist(v)
//   pass        : signature == EXPECTED, valid from done onward
//   vec_idx     : vector currently applied
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned N_SAMPLES     = 3,
  parameter logic [15:0] EXPECTED      = 16'h3812
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        dut_out,
  output logic        in1,
  output logic        in2,
  output logic        in3,
  output logic        in4,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic        pass,
  output logic [3:0]  vec_idx
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] LAST_STEP = N_INPUTS'(N_VECTORS - 1);

  state_t              state;
  logic [CW-1:0]       settle_cnt;
  logic [N_INPUTS-1:0] step;
  logic [N_INPUTS-1:0] step_next;
  logic [N_INPUTS-1:0] vec_next;
  logic [N_INPUTS-1:0] wr_idx;
  logic [15:0]         sig_next;
  logic                start_go;
  logic                abort_go;
  logic                vote_clear;
  logic                vote_en;
  logic                vote_last;
  logic                vote_valid;
  logic                vote_bit;

  always_comb begin
    start_go   = (state == IDLE) && start && !abort;
    abort_go   = (state != IDLE) && abort;
    vote_clear = start_go || abort_go;
    vote_en    = (state == SAMPLE) && !abort;
    step_next  = step + 1'b1;
`ifdef SWEEP_GRAY_EN
    vec_next   = to_gray(step_next);
`else
    vec_next   = step_next;
`endif
  end

  // The vote for a vector lands one cycle after its last sample, by which
  // time the FSM has moved on; wr_idx remembers where it belongs.
  always_comb begin
    sig_next = signature;
    if (vote_valid) sig_next[wr_idx] = vote_bit;
  end

  sample_voter #(
    .N_SAMPLES(N_SAMPLES)
  ) u_voter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (vote_clear),
    .enable(vote_en),
    .din   (dut_out),
    .last  (vote_last),
    .valid (vote_valid),
    .result(vote_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      settle_cnt        <= '0;
      step              <= '0;
      wr_idx            <= '0;
      vec_idx           <= '0;
      {in1, in2, in3, in4} <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      signature         <= '0;
      pass              <= 1'b0;
    end else begin
      done <= 1'b0;
      if (vote_valid) signature <= sig_next;

      if (abort_go) begin
        state             <= IDLE;
        busy              <= 1'b0;
        pass              <= 1'b0;
        {in1, in2, in3, in4} <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_go) begin
              signature         <= '0;
              pass              <= 1'b0;
              step              <= '0;
              vec_idx           <= '0;
              {in1, in2, in3, in4} <= '0;
              settle_cnt        <= '0;
              busy              <= 1'b1;
              state             <= SETTLE;
            end
          end
          SETTLE: begin
            if (settle_cnt == SETTLE_LAST) state <= SAMPLE;
            else settle_cnt <= settle_cnt + 1'b1;
          end
          SAMPLE: begin
            if (vote_last) begin
              wr_idx <= vec_idx;
              if (step == LAST_STEP) begin
                state <= DONE;
              end else begin
                step              <= step_next;
                vec_idx           <= vec_next;
                {in1, in2, in3, in4} <= vec_next;
                settle_cnt        <= '0;
                state             <= SETTLE;
              end
            end
          end
          DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (sig_next == EXPECTED);
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential test initiator for our 4-input NOR/NOT logic netlists, e.g. m0x3812.
- Drives all 16 input combinations onto the netlist's in1..in4, waits a programmable settle time per vector, samples the netlist output, and assembles a 16-bit truth-table signature.
- Compares the signature against the expected hex function ID and reports pass/fail.
- Sits between the bench/host controller and one combinational netlist instance.

Parameters:
- SETTLE_CYCLES, 64, clock cycles the vector is held before sampling begins (minimum 1)
- N_SAMPLES, 3, consecutive samples per vector, majority-voted (odd, 1..7)
- EXPECTED, 16'h3812, expected signature

Ports:
- clk  input  1  single clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a sweep when idle
- abort  input  1  one-cycle pulse; terminates the sweep
- dut_out  input  1  netlist output, asynchronous to clk
- in1  output  1  netlist input 1
- in2  output  1  netlist input 2
- in3  output  1  netlist input 3
- in4  output  1  netlist input 4
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse at sweep completion
- signature  output  16  captured truth table
- pass  output  1  signature == EXPECTED, valid from done onward
- vec_idx  output  4  current vector index

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: in1..in4=0, busy=0, done=0, signature=0, pass=0, vec_idx=0, FSM=IDLE.
- Vector mapping: for vector index v, in1=v[3], in2=v[2], in3=v[1], in4=v[0]. The voted sample for v is written into signature[v].
- dut_out passes through a 2-flop synchronizer before any use.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1: clear signature and pass, set vec_idx=0, drive vector 0, set busy=1, go to SETTLE.
  - start while busy is ignored.
- SETTLE:
  - Counter runs 0..SETTLE_CYCLES-1.
  - At terminal count, go to SAMPLE.
  - Vector outputs are stable throughout SETTLE and SAMPLE.
- SAMPLE:
  - Capture N_SAMPLES consecutive synchronized values; the majority result goes to signature[vec_idx].
  - If vec_idx==15, go to DONE.
  - Otherwise increment vec_idx, drive the new vector the next cycle, and reenter SETTLE with the counter cleared.
- DONE (one cycle):
  - done=1, pass registered from the signature compare, busy=0.
  - Return to IDLE. signature and pass hold until the next start.
- Latency: start to done = 16*(SETTLE_CYCLES+N_SAMPLES) + 2 cycles. Verification checks this exactly.
- abort in any busy state:
  - Next cycle: IDLE, busy=0, no done pulse, pass=0, in1..in4=0.
  - signature keeps the partial data.
  - abort and start in the same cycle: abort wins, start is ignored.
- rst_n deassertion mid-sweep: outputs return to reset values immediately (asynchronously); no partial done.
- Counter width: $clog2(SETTLE_CYCLES+1). Wrap-around of vec_idx past 15 never occurs.

Optional Feature:
- Macro: SWEEP_GRAY_EN.
- Defined:
  - Vectors are applied in Gray-code order: step k drives g = k ^ (k>>1), so only one netlist input toggles per step. This limits hazard-driven glitches in the NOR network.
  - The voted sample is written to signature[g]; vec_idx reports g.
  - The final signature is identical to the binary-order sweep, and the done latency is unchanged.
- Undefined: binary order; vec_idx equals the step count.

Decomposition:
- Package tts_pkg:
  - state enum (IDLE, SETTLE, SAMPLE, DONE)
  - N_INPUTS=4, N_VECTORS=16
  - function to_gray
- Sub-module sample_voter:
  - contains the synchronizer, the N_SAMPLES shift/count, and the majority output
  - clear and enable inputs
  - result valid one cycle after the last sample

Test Plan:
- dut_out tied to a behavioural copy of the m0x3812 function, SETTLE_CYCLES=4, start pulse -> done after 16*7+2=114 cycles, signature=16'h3812, pass=1.
- Stub dut_out=in1 -> signature=16'hFF00, pass=0. Stub dut_out=in4 -> signature=16'hAAAA, pass=0.
- Stub dut_out=in4, pulse abort during vec_idx=5 -> busy drops next cycle, no done, in1..in4=0, signature[4:0]=5'b01010.
- start pulse while busy, and start+abort in the same cycle -> start ignored, abort taken, latency unaffected.
- rst_n asserted at vec_idx=9 SETTLE -> all outputs 0 immediately; a new start gives a correct full sweep.
- dut_out glitches one cycle low in the middle of the 3-sample window for a 1-vector, N_SAMPLES=3 -> majority keeps 1.
- With SWEEP_GRAY_EN: vec_idx sequence 0,1,3,2,6,…; at most one of in1..in4 changes per step; final signature matches the binary run.
